game_table_render: RTL and testbench



---
 rtl/game_table_render.sv | 213 +++++++++++++++++++++
 tb/tb_game_table_render.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/game_table_render.sv
// SVGA 800x600@60 renderer for the 10x10 game table: a per-frame snapshot feeds a 2-stage pixel pipeline.
// Defining GRID_LINES_EN overlays 12'h444 cell borders on the board.
module game_table_render #(
    parameter int          BOARD_X0  = 200,
    parameter int          BOARD_Y0  = 100,
    parameter int          CELL_SIZE = 40,
    parameter logic [11:0] FG_COLOR  = 12'hFFF,
    parameter logic [11:0] BG_COLOR  = 12'h000,
    parameter int          H_VISIBLE = 800,
    parameter int          H_FRONT   = 40,
    parameter int          H_SYNC    = 128,
    parameter int          H_BACK    = 88,
    parameter int          V_VISIBLE = 600,
    parameter int          V_FRONT   = 1,
    parameter int          V_SYNC    = 4,
    parameter int          V_BACK    = 23
) (
    input  logic         clk_40M,
    input  logic         rst,
    input  logic [99:0]  game_table,
    output logic [3:0]   vga_r,
    output logic [3:0]   vga_g,
    output logic [3:0]   vga_b,
    output logic         vga_hsync,
    output logic         vga_vsync,
    output logic         frame_tick
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int OW      = $clog2(CELL_SIZE + 1);
    localparam int BOARD_W = 10 * CELL_SIZE;

    localparam logic [HW-1:0] H_LAST       = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS_END    = HW'(H_VISIBLE);
    localparam logic [HW-1:0] H_SYNC_START = HW'(H_VISIBLE + H_FRONT);
    localparam logic [HW-1:0] H_SYNC_END   = HW'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [HW-1:0] X_START      = HW'(BOARD_X0);
    localparam logic [HW-1:0] X_END        = HW'(BOARD_X0 + BOARD_W);
    localparam logic [HW-1:0] X_LAST       = HW'(BOARD_X0 + BOARD_W - 1);

    localparam logic [VW-1:0] V_LAST       = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS_END    = VW'(V_VISIBLE);
    localparam logic [VW-1:0] V_SYNC_START = VW'(V_VISIBLE + V_FRONT);
    localparam logic [VW-1:0] V_SYNC_END   = VW'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [VW-1:0] Y_START      = VW'(BOARD_Y0);
    localparam logic [VW-1:0] Y_END        = VW'(BOARD_Y0 + BOARD_W);
    localparam logic [VW-1:0] Y_LAST       = VW'(BOARD_Y0 + BOARD_W - 1);

    localparam logic [OW-1:0] OFF_LAST     = OW'(CELL_SIZE - 1);

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic [OW-1:0] x_off;
    logic [OW-1:0] y_off;
    logic [3:0]    col;
    logic [3:0]    row;
    logic [99:0]   snapshot_reg;
    logic          frame_tick_reg;

    logic          in_x;
    logic          in_y;
    logic          visible;
    logic          hsync_now;
    logic          vsync_now;
    logic          snap_now;

    logic          s1_visible;
    logic          s1_inside;
    logic [6:0]    s1_index;
    logic          s1_hsync;
    logic          s1_vsync;
`ifdef GRID_LINES_EN
    logic          s1_grid;
`endif

    logic [11:0]   pixel_color;
    logic [11:0]   color_reg;
    logic          hsync_reg;
    logic          vsync_reg;

    always_comb begin
        in_x      = (h_cnt >= X_START) && (h_cnt < X_END);
        in_y      = (v_cnt >= Y_START) && (v_cnt < Y_END);
        visible   = (h_cnt < H_VIS_END) && (v_cnt < V_VIS_END);
        hsync_now = (h_cnt >= H_SYNC_START) && (h_cnt < H_SYNC_END);
        vsync_now = (v_cnt >= V_SYNC_START) && (v_cnt < V_SYNC_END);
        snap_now  = (h_cnt == '0) && (v_cnt == V_VIS_END);
    end

    always_ff @(posedge clk_40M or negedge rst) begin
        if (!rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    // Cell counters sit at zero everywhere outside the board, so they are already zero at its top-left edge.
    always_ff @(posedge clk_40M or negedge rst) begin
        if (!rst) begin
            x_off <= '0;
            col   <= '0;
        end else if (in_x && (h_cnt != X_LAST)) begin
            if (x_off == OFF_LAST) begin
                x_off <= '0;
                col   <= col + 1'b1;
            end else begin
                x_off <= x_off + 1'b1;
            end
        end else begin
            x_off <= '0;
            col   <= '0;
        end
    end

    always_ff @(posedge clk_40M or negedge rst) begin
        if (!rst) begin
            y_off <= '0;
            row   <= '0;
        end else if (h_cnt == H_LAST) begin
            if (in_y && (v_cnt != Y_LAST)) begin
                if (y_off == OFF_LAST) begin
                    y_off <= '0;
                    row   <= row + 1'b1;
                end else begin
                    y_off <= y_off + 1'b1;
                end
            end else begin
                y_off <= '0;
                row   <= '0;
            end
        end
    end

    always_ff @(posedge clk_40M or negedge rst) begin
        if (!rst) begin
            snapshot_reg   <= '0;
            frame_tick_reg <= 1'b0;
        end else begin
            frame_tick_reg <= snap_now;
            if (snap_now) begin
                snapshot_reg <= game_table;
            end
        end
    end

    // row*10 as shift-add keeps stage 1 free of multipliers.
    always_ff @(posedge clk_40M or negedge rst) begin
        if (!rst) begin
            s1_visible <= 1'b0;
            s1_inside  <= 1'b0;
            s1_index   <= '0;
            s1_hsync   <= 1'b0;
            s1_vsync   <= 1'b0;
`ifdef GRID_LINES_EN
            s1_grid    <= 1'b0;
`endif
        end else begin
            s1_visible <= visible;
            s1_inside  <= in_x && in_y;
            s1_index   <= ({3'b000, row} << 3) + ({3'b000, row} << 1) + {3'b000, col};
            s1_hsync   <= hsync_now;
            s1_vsync   <= vsync_now;
`ifdef GRID_LINES_EN
            s1_grid    <= (x_off == '0) || (y_off == '0) || (h_cnt == X_LAST) || (v_cnt == Y_LAST);
`endif
        end
    end

    always_comb begin
        pixel_color = BG_COLOR;
        if (!s1_visible) begin
            pixel_color = 12'h000;
        end else if (s1_inside) begin
`ifdef GRID_LINES_EN
            if (s1_grid) begin
                pixel_color = 12'h444;
            end else begin
                pixel_color = snapshot_reg[s1_index] ? FG_COLOR : BG_COLOR;
            end
`else
            pixel_color = snapshot_reg[s1_index] ? FG_COLOR : BG_COLOR;
`endif
        end
    end

    always_ff @(posedge clk_40M or negedge rst) begin
        if (!rst) begin
            color_reg <= '0;
            hsync_reg <= 1'b0;
            vsync_reg <= 1'b0;
        end else begin
            color_reg <= pixel_color;
            hsync_reg <= s1_hsync;
            vsync_reg <= s1_vsync;
        end
    end

    assign vga_r      = color_reg[11:8];
    assign vga_g      = color_reg[7:4];
    assign vga_b      = color_reg[3:0];
    assign vga_hsync  = hsync_reg;
    assign vga_vsync  = vsync_reg;
    assign frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_game_table_render.sv
// Random and directed checking of game_table_render: a compact-timing instance is compared cycle by cycle
// with a pixel-position model, and a default-timing instance is checked over its first lines.
module tb_game_table_render;

    typedef struct {
        int ht, hv, hs0, hs1, vt, vv, vs0, vs1, x0, y0, c;
    } geom_t;

    localparam geom_t GS = '{84, 64, 68, 76, 54, 48, 49, 51, 10, 6, 4};
    localparam geom_t GF = '{1056, 800, 840, 968, 628, 600, 601, 605, 200, 100, 40};
    localparam int    FS = 84 * 54;

    logic        clk;
    logic        rst;
    logic [99:0] game_table;

    logic [3:0]  s_r, s_g, s_b;
    logic        s_hs, s_vs, s_tick;
    logic [3:0]  f_r, f_g, f_b;
    logic        f_hs, f_vs, f_tick;

    int          checks;
    int          errors;
    int          n;
    int          ticks;
    bit          seen_hs_s;
    bit          seen_hs_f;
    logic [99:0] snap_s;
    logic [99:0] snap_f;

    game_table_render #(
        .BOARD_X0(10), .BOARD_Y0(6), .CELL_SIZE(4),
        .H_VISIBLE(64), .H_FRONT(4), .H_SYNC(8), .H_BACK(8),
        .V_VISIBLE(48), .V_FRONT(1), .V_SYNC(2), .V_BACK(3)
    ) u_dut (
        .clk_40M(clk), .rst(rst), .game_table(game_table),
        .vga_r(s_r), .vga_g(s_g), .vga_b(s_b),
        .vga_hsync(s_hs), .vga_vsync(s_vs), .frame_tick(s_tick)
    );

    game_table_render u_full (
        .clk_40M(clk), .rst(rst), .game_table(game_table),
        .vga_r(f_r), .vga_g(f_g), .vga_b(f_b),
        .vga_hsync(f_hs), .vga_vsync(f_vs), .frame_tick(f_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s (n=%0d): got %0h, expected %0h", tag, n, got, exp);
            if (errors >= 50) begin
                $display("Simulation finished: %0d checks, %0d errors", checks, errors);
                $finish;
            end
        end
    endtask

    // Expected {rgb, hsync, vsync, tick} after edge n counted from reset release.
    function automatic logic [14:0] model_out(geom_t g, int edge_n, logic [99:0] snap);
        int frame, p, h, v, col, row;
        logic [11:0] rgb;
        logic hs, vs, tk;
        frame = g.ht * g.vt;
        tk  = (edge_n >= 1) && (((edge_n - 1) % frame) == g.vv * g.ht);
        rgb = 12'h000;
        hs  = 1'b0;
        vs  = 1'b0;
        if (edge_n >= 2) begin
            p  = (edge_n - 2) % frame;
            h  = p % g.ht;
            v  = p / g.ht;
            hs = (h >= g.hs0) && (h < g.hs1);
            vs = (v >= g.vs0) && (v < g.vs1);
            if (h < g.hv && v < g.vv && h >= g.x0 && h < g.x0 + 10 * g.c &&
                v >= g.y0 && v < g.y0 + 10 * g.c) begin
                col = (h - g.x0) / g.c;
                row = (v - g.y0) / g.c;
                rgb = snap[row * 10 + col] ? 12'hFFF : 12'h000;
`ifdef GRID_LINES_EN
                if ((h - g.x0) % g.c == 0 || (v - g.y0) % g.c == 0 ||
                    h == g.x0 + 10 * g.c - 1 || v == g.y0 + 10 * g.c - 1)
                    rgb = 12'h444;
`endif
            end
        end
        return {rgb, hs, vs, tk};
    endfunction

    function automatic logic [99:0] rand100();
        logic [127:0] w;
        w = {$urandom, $urandom, $urandom, $urandom};
        return w[99:0];
    endfunction

    task automatic step_checks();
        check("pix_small", {17'd0, s_r, s_g, s_b, s_hs, s_vs, s_tick}, {17'd0, model_out(GS, n, snap_s)});
        check("pix_full", {17'd0, f_r, f_g, f_b, f_hs, f_vs, f_tick}, {17'd0, model_out(GF, n, snap_f)});
        if (s_tick) ticks++;
        if (!seen_hs_s && s_hs) begin
            check("first_hsync_small", n, GS.hs0 + 2);
            seen_hs_s = 1'b1;
        end
        if (!seen_hs_f && f_hs) begin
            check("first_hsync_full", n, GF.hs0 + 2);
            seen_hs_f = 1'b1;
        end
        if (n >= 1 && ((n - 1) % FS) == GS.vv * GS.ht) snap_s = game_table;
        if (n >= 1 && ((n - 1) % (GF.ht * GF.vt)) == GF.vv * GF.ht) snap_f = game_table;
    endtask

    task automatic run_until(input int target, input bit rnd);
        while (n < target) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            step_checks();
            if (rnd && $urandom_range(0, 199) == 0) game_table = rand100();
        end
    endtask

    task automatic restart();
        n         = 0;
        ticks     = 0;
        seen_hs_s = 1'b0;
        seen_hs_f = 1'b0;
        snap_s    = '0;
        snap_f    = '0;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b0;
        game_table = '0;
        restart();
        repeat (3) @(negedge clk);
        check("reset_rgb", {20'd0, s_r, s_g, s_b}, 32'd0);
        check("reset_sync", {29'd0, s_hs, s_vs, s_tick}, 32'd0);
        game_table = 100'd1;
        rst = 1'b1;

        // bit 0 shown in frame 1, bit 99 in frame 2, all ones from frame 3 (set mid-frame 2)
        run_until(FS + 10, 1'b0);
        game_table     = '0;
        game_table[99] = 1'b1;
        run_until(2 * FS + 24 * GS.ht, 1'b0);
        game_table = '1;
        run_until(4 * FS, 1'b0);
        check("tick_count", ticks, 4);

        run_until(6 * FS, 1'b1);
        game_table = '1;
        // Stop where the compact instance is inside its hsync pulse so the async clear is visible.
        run_until(6 * FS + 25 * GS.ht + 73, 1'b0);
        #2 rst = 1'b0;
        #1;
        check("async_rst_rgb", {20'd0, s_r, s_g, s_b}, 32'd0);
        check("async_rst_sync", {29'd0, s_hs, s_vs, s_tick}, 32'd0);
        check("async_rst_full", {17'd0, f_r, f_g, f_b, f_hs, f_vs, f_tick}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        restart();
        rst = 1'b1;

        run_until(FS + FS / 2, 1'b1);
        check("tick_count_after_rst", ticks, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
